// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the pipelined instruction memory (NOP word, legal read latencies)
package imem_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
  function automatic int legal_lat(input int l);
    return (l < LAT_MIN) ? LAT_MIN : (l > LAT_MAX) ? LAT_MAX : l;
  endfunction
endpackage

// File: rtl/imem_if.sv
// imem_if: fetch req/rsp handshake plus program-load port; master = fetch unit/loader, slave = memory
interface imem_if #(parameter int ADDR_W = 64, parameter int DATA_W = 32);
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic rsp_fault;
  logic prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/imem_stage.sv
// imem_stage: one read-pipeline register (valid/word/fault); loads in_* when adv is high, holds otherwise, clears on reset
module imem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_word,
  input  logic              in_fault,
  output logic              valid,
  output logic [DATA_W-1:0] word,
  output logic              fault
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= '0;
      fault <= 1'b0;
    end else if (adv) begin
      valid <= in_valid;
      word  <= in_word;
      fault <= in_fault;
    end
  end
endmodule

// File: rtl/imem_pipelined.sv
// imem_pipelined: word-addressed instruction ROM/RAM with LATENCY-deep stallable read pipeline; ports clk, reset, bus (imem_if.slave: req/rsp handshake, prog load)
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input logic   clk,
  input logic   reset,
  imem_if.slave bus
);
  localparam int LAT = legal_lat(LATENCY);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [IW-1:0] ridx, widx;
  logic rfault, wfault, fire;
  logic [DATA_W-1:0] rword;
  logic [LAT-1:0] adv;
  logic v [LAT];
  logic [DATA_W-1:0] w [LAT];
  logic f [LAT];
  logic iv [LAT];
  logic [DATA_W-1:0] iw [LAT];
  logic ifl [LAT];
  assign ridx   = bus.req_addr[IW+1:2];
  assign widx   = bus.prog_addr[IW+1:2];
  assign rfault = (|bus.req_addr[1:0]) || (bus.req_addr >= LIMIT);
  assign wfault = (|bus.prog_addr[1:0]) || (bus.prog_addr >= LIMIT);
  // faulting fetches never touch the array
  assign rword  = rfault ? DATA_W'(NOP) : mem[ridx];
  // a stage may load when it is empty or its successor is taking its entry
  always_comb begin
    logic a;
    adv = '0;
    a = !v[LAT-1] || bus.rsp_ready;
    adv[LAT-1] = a;
    for (int i = LAT - 2; i >= 0; i--) begin
      a = !v[i] || a;
      adv[i] = a;
    end
  end
  assign bus.req_ready = !reset && adv[0];
  assign fire = bus.req_valid && bus.req_ready;
  // nonblocking write gives read-before-write on a same-cycle fetch
  always_ff @(posedge clk) begin
    if (!reset && bus.prog_we && !wfault) mem[widx] <= bus.prog_data;
  end
  for (genvar g = 0; g < LAT; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign iv[g]  = fire;
      assign iw[g]  = rword;
      assign ifl[g] = rfault;
    end else begin : g_body
      assign iv[g]  = v[g-1];
      assign iw[g]  = w[g-1];
      assign ifl[g] = f[g-1];
    end
    imem_stage #(.DATA_W(DATA_W)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .adv      (adv[g]),
      .in_valid (iv[g]),
      .in_word  (iw[g]),
      .in_fault (ifl[g]),
      .valid    (v[g]),
      .word     (w[g]),
      .fault    (f[g])
    );
  end
  assign bus.rsp_valid = v[LAT-1];
  assign bus.rsp_instr = w[LAT-1];
  assign bus.rsp_fault = f[LAT-1];
endmodule

// File: tb/tb_imem_pipelined.sv
// tb_imem_pipelined: directed table and sequence checks of imem_pipelined at LATENCY 1 (dut_a) and 2 (dut_b)
module tb_imem_pipelined;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;
  vec_t tbl [12];
  imem_if #(.ADDR_W(64), .DATA_W(32)) ia ();
  imem_if #(.ADDR_W(64), .DATA_W(32)) ib ();
  imem_pipelined #(.ADDR_W(64), .DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  imem_pipelined #(.ADDR_W(64), .DATA_W(32), .DEPTH(256), .LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic prog(input logic [63:0] addr, input logic [31:0] data);
    ia.prog_we = 1'b1; ia.prog_addr = addr; ia.prog_data = data;
    ib.prog_we = 1'b1; ib.prog_addr = addr; ib.prog_data = data;
    @(posedge clk); #1;
    ia.prog_we = 1'b0;
    ib.prog_we = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{64'h0,                  32'h00A0_0093, 1'b0};
    tbl[1]  = '{64'h2,                  NOP,           1'b1};
    tbl[2]  = '{64'h400,                NOP,           1'b1};
    tbl[3]  = '{64'h4,                  32'h1111_1111, 1'b0};
    tbl[4]  = '{64'h8,                  32'h2222_2222, 1'b0};
    tbl[5]  = '{64'hC,                  32'h3333_3333, 1'b0};
    tbl[6]  = '{64'h3FC,                32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{64'h3FD,                NOP,           1'b1};
    tbl[8]  = '{64'h10,                 32'h0,         1'b0};
    tbl[9]  = '{64'h1,                  NOP,           1'b1};
    tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,          1'b1};
    tbl[11] = '{64'h1000,               NOP,           1'b1};
    ia.req_valid = 1'b1; ia.req_addr = '0; ia.rsp_ready = 1'b1;
    ib.req_valid = 1'b0; ib.req_addr = '0; ib.rsp_ready = 1'b1;
    ia.prog_we = 1'b1; ia.prog_addr = 64'h10; ia.prog_data = 32'h9999_9999;
    ib.prog_we = 1'b1; ib.prog_addr = 64'h10; ib.prog_data = 32'h9999_9999;
    repeat (2) @(posedge clk);
    #1;
    chk("reset a rsp_valid", 64'(ia.rsp_valid), 64'd0);
    chk("reset a rsp_instr", 64'(ia.rsp_instr), 64'd0);
    chk("reset a rsp_fault", 64'(ia.rsp_fault), 64'd0);
    chk("reset a req_ready", 64'(ia.req_ready), 64'd0);
    chk("reset b rsp_valid", 64'(ib.rsp_valid), 64'd0);
    chk("reset b req_ready", 64'(ib.req_ready), 64'd0);
    ia.req_valid = 1'b0;
    ia.prog_we = 1'b0;
    ib.prog_we = 1'b0;
    reset = 1'b0;
    prog(64'h0,   32'h00A0_0093);
    prog(64'h4,   32'h1111_1111);
    prog(64'h8,   32'h2222_2222);
    prog(64'hC,   32'h3333_3333);
    prog(64'h3FC, 32'hDEAD_BEEF);
    prog(64'h5,   32'h5555_5555);
    prog(64'h404, 32'h4444_4444);
    prog(64'h400, 32'h6666_6666);
    for (int i = 0; i < 12; i++) begin
      ia.req_valid = 1'b1;
      ia.req_addr = tbl[i].addr;
      #1;
      chk($sformatf("v%0d req_ready", i), 64'(ia.req_ready), 64'd1);
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      chk($sformatf("v%0d rsp_valid", i), 64'(ia.rsp_valid), 64'd1);
      chk($sformatf("v%0d rsp_instr", i), 64'(ia.rsp_instr), 64'(tbl[i].instr));
      chk($sformatf("v%0d rsp_fault", i), 64'(ia.rsp_fault), 64'(tbl[i].fault));
    end
    @(posedge clk); #1;
    chk("a drain rsp_valid", 64'(ia.rsp_valid), 64'd0);
    ia.req_valid = 1'b1; ia.req_addr = 64'h14;
    ia.prog_we = 1'b1; ia.prog_addr = 64'h14; ia.prog_data = 32'hFE41_8E63;
    #1;
    chk("rbw req_ready", 64'(ia.req_ready), 64'd1);
    @(posedge clk); #1;
    ia.prog_we = 1'b0;
    chk("rbw old valid", 64'(ia.rsp_valid), 64'd1);
    chk("rbw old instr", 64'(ia.rsp_instr), 64'd0);
    @(posedge clk); #1;
    ia.req_valid = 1'b0;
    chk("rbw new instr", 64'(ia.rsp_instr), 64'hFE41_8E63);
    ib.rsp_ready = 1'b0;
    ib.req_valid = 1'b1; ib.req_addr = 64'h0;
    #1;
    chk("l2 ready empty", 64'(ib.req_ready), 64'd1);
    @(posedge clk); #1;
    ib.req_addr = 64'h4;
    #1;
    chk("l2 latency valid", 64'(ib.rsp_valid), 64'd0);
    chk("l2 ready half", 64'(ib.req_ready), 64'd1);
    @(posedge clk); #1;
    chk("l2 first valid", 64'(ib.rsp_valid), 64'd1);
    chk("l2 first instr", 64'(ib.rsp_instr), 64'h00A0_0093);
    ib.req_addr = 64'h8;
    #1;
    chk("l2 ready full", 64'(ib.req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid", i), 64'(ib.rsp_valid), 64'd1);
      chk($sformatf("stall%0d instr", i), 64'(ib.rsp_instr), 64'h00A0_0093);
      chk($sformatf("stall%0d fault", i), 64'(ib.rsp_fault), 64'd0);
      chk($sformatf("stall%0d ready", i), 64'(ib.req_ready), 64'd0);
    end
    ib.rsp_ready = 1'b1;
    #1;
    chk("l2 ready release", 64'(ib.req_ready), 64'd1);
    @(posedge clk); #1;
    ib.req_valid = 1'b0;
    chk("drain1 valid", 64'(ib.rsp_valid), 64'd1);
    chk("drain1 instr", 64'(ib.rsp_instr), 64'h1111_1111);
    @(posedge clk); #1;
    chk("drain2 valid", 64'(ib.rsp_valid), 64'd1);
    chk("drain2 instr", 64'(ib.rsp_instr), 64'h2222_2222);
    @(posedge clk); #1;
    chk("drain3 valid", 64'(ib.rsp_valid), 64'd0);
    ib.rsp_ready = 1'b0;
    ib.req_valid = 1'b1; ib.req_addr = 64'h2;
    @(posedge clk); #1;
    ib.req_addr = 64'h8;
    @(posedge clk); #1;
    ib.req_valid = 1'b0;
    chk("flight valid", 64'(ib.rsp_valid), 64'd1);
    chk("flight fault", 64'(ib.rsp_fault), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid reset valid", 64'(ib.rsp_valid), 64'd0);
    chk("mid reset fault", 64'(ib.rsp_fault), 64'd0);
    chk("mid reset instr", 64'(ib.rsp_instr), 64'd0);
    chk("mid reset ready", 64'(ib.req_ready), 64'd0);
    reset = 1'b0;
    ib.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post reset%0d valid", i), 64'(ib.rsp_valid), 64'd0);
    end
    ib.req_valid = 1'b1; ib.req_addr = 64'h4;
    @(posedge clk); #1;
    ib.req_valid = 1'b0;
    chk("kept early valid", 64'(ib.rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("kept valid", 64'(ib.rsp_valid), 64'd1);
    chk("kept instr", 64'(ib.rsp_instr), 64'h1111_1111);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
